mem_arbiter: RTL

Two-port to one-port memory arbiter between the pipeline's instruction-fetch port and its data port and the single shared memory/MMU port. It holds one outstanding transaction at a time. Data accesses get priority and a starvation guard protects fetch. A timeout turns a hung access into a bus error that the pipeline's exception logic can consume. It sits between the `pc_reg`/`mem` stage request signals and the memory-side interface.

---
 rtl/mem_arbiter.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) to one-port memory arbiter with data priority, a fetch
// starvation guard, an access timeout that reports a bus error, and fetch flush.
module mem_arbiter #(
    parameter int STARVE_MAX  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ena_i,
    input  logic [31:0] i_addr_i,
    input  logic        flush_i,
    output logic [31:0] i_data_o,
    output logic        i_valid_o,
    output logic        i_err_o,
    input  logic        d_ena_i,
    input  logic        d_w_r_i,
    input  logic [31:0] d_addr_i,
    input  logic [3:0]  d_sel_i,
    input  logic [31:0] d_wdata_i,
    output logic [31:0] d_data_o,
    output logic        d_valid_o,
    output logic        d_err_o,
    output logic        ram_ena_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [3:0]  ram_sel_o,
    output logic [31:0] ram_wdata_o,
    input  logic [31:0] ram_rdata_i,
    input  logic        ram_ready_i
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_I_BUSY = 2'd1;
    localparam logic [1:0] ST_D_BUSY = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int SW = $clog2(STARVE_MAX + 2);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYC - 1);

    logic [1:0]    state_q, state_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          drop_q, drop_d;
    logic          ram_ena_q, ram_ena_d;
    logic          ram_we_q, ram_we_d;
    logic [31:0]   ram_addr_q, ram_addr_d;
    logic [3:0]    ram_sel_q, ram_sel_d;
    logic [31:0]   ram_wdata_q, ram_wdata_d;
    logic [31:0]   i_data_q, i_data_d;
    logic          i_valid_q, i_valid_d;
    logic          i_err_q, i_err_d;
    logic [31:0]   d_data_q, d_data_d;
    logic          d_valid_q, d_valid_d;
    logic          d_err_q, d_err_d;

    logic          grant_d_s;
    logic          grant_i_s;
    logic          drop_now_s;

    // Arbitration decision, only acted on in IDLE
    always_comb begin
        grant_d_s  = d_ena_i & (~i_ena_i | (starve_cnt_q < STARVE_LIM));
        grant_i_s  = ~grant_d_s & i_ena_i;
        drop_now_s = drop_q | flush_i;
    end

    // Next-state, counters, access attributes and completion outputs
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        drop_d       = drop_q;
        ram_ena_d    = ram_ena_q;
        ram_we_d     = ram_we_q;
        ram_addr_d   = ram_addr_q;
        ram_sel_d    = ram_sel_q;
        ram_wdata_d  = ram_wdata_q;
        i_data_d     = i_data_q;
        i_valid_d    = 1'b0;
        i_err_d      = 1'b0;
        d_data_d     = d_data_q;
        d_valid_d    = 1'b0;
        d_err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                drop_d = 1'b0;
                if (grant_d_s) begin
                    state_d     = ST_D_BUSY;
                    ram_ena_d   = 1'b1;
                    ram_we_d    = d_w_r_i;
                    ram_addr_d  = d_addr_i;
                    ram_sel_d   = d_sel_i;
                    ram_wdata_d = d_wdata_i;
                    tmo_cnt_d   = {TW{1'b0}};
                    if (i_ena_i && (starve_cnt_q < STARVE_LIM)) begin
                        starve_cnt_d = starve_cnt_q + SW'(1);
                    end else begin
                        starve_cnt_d = starve_cnt_q;
                    end
                end else if (grant_i_s) begin
                    state_d      = ST_I_BUSY;
                    ram_ena_d    = 1'b1;
                    ram_we_d     = 1'b0;
                    ram_addr_d   = i_addr_i;
                    ram_sel_d    = 4'hF;
                    ram_wdata_d  = 32'h0000_0000;
                    tmo_cnt_d    = {TW{1'b0}};
                    starve_cnt_d = {SW{1'b0}};
                    drop_d       = flush_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_I_BUSY: begin
                drop_d = drop_now_s;
                if (ram_ready_i) begin
                    state_d   = ST_DONE;
                    ram_ena_d = 1'b0;
                    i_valid_d = ~drop_now_s;
                    if (!drop_now_s) begin
                        i_data_d = ram_rdata_i;
                    end else begin
                        i_data_d = i_data_q;
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d   = ST_DONE;
                    ram_ena_d = 1'b0;
                    i_valid_d = ~drop_now_s;
                    i_err_d   = ~drop_now_s;
                    if (!drop_now_s) begin
                        i_data_d = 32'h0000_0000;
                    end else begin
                        i_data_d = i_data_q;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            ST_D_BUSY: begin
                if (ram_ready_i) begin
                    state_d   = ST_DONE;
                    ram_ena_d = 1'b0;
                    d_valid_d = 1'b1;
                    d_data_d  = ram_we_q ? 32'h0000_0000 : ram_rdata_i;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d   = ST_DONE;
                    ram_ena_d = 1'b0;
                    d_valid_d = 1'b1;
                    d_err_d   = 1'b1;
                    d_data_d  = 32'h0000_0000;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            ST_DONE: begin
                // No grant here so the finished requester can drop its enable
                state_d = ST_IDLE;
                drop_d  = 1'b0;
            end
            default: begin
                state_d   = ST_IDLE;
                ram_ena_d = 1'b0;
                drop_d    = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            starve_cnt_q <= {SW{1'b0}};
            tmo_cnt_q    <= {TW{1'b0}};
            drop_q       <= 1'b0;
            ram_ena_q    <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= 32'h0000_0000;
            ram_sel_q    <= 4'h0;
            ram_wdata_q  <= 32'h0000_0000;
            i_data_q     <= 32'h0000_0000;
            i_valid_q    <= 1'b0;
            i_err_q      <= 1'b0;
            d_data_q     <= 32'h0000_0000;
            d_valid_q    <= 1'b0;
            d_err_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            drop_q       <= drop_d;
            ram_ena_q    <= ram_ena_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_sel_q    <= ram_sel_d;
            ram_wdata_q  <= ram_wdata_d;
            i_data_q     <= i_data_d;
            i_valid_q    <= i_valid_d;
            i_err_q      <= i_err_d;
            d_data_q     <= d_data_d;
            d_valid_q    <= d_valid_d;
            d_err_q      <= d_err_d;
        end
    end

    assign i_data_o    = i_data_q;
    assign i_valid_o   = i_valid_q;
    assign i_err_o     = i_err_q;
    assign d_data_o    = d_data_q;
    assign d_valid_o   = d_valid_q;
    assign d_err_o     = d_err_q;
    assign ram_ena_o   = ram_ena_q;
    assign ram_we_o    = ram_we_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_sel_o   = ram_sel_q;
    assign ram_wdata_o = ram_wdata_q;

endmodule
